// File: rtl/prefix_sub_pipe.sv
// prefix_sub_pipe: two-stage pipelined parallel-prefix subtractor.
// Computes D = A - B - BI (mod 2^Width) as A + ~B + ~BI using a Kogge-Stone
// carry tree. The tree is split at the pipeline boundary: stage 1 finishes
// the prefix within each half, and stage 2 applies the last level that folds
// the lower-half carry into the upper half. Valid/ready handshakes on both
// sides, at most two operations in flight.
module prefix_sub_pipe #(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] A,
  input  logic [Width-1:0] B,
  input  logic             BI,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] D,
  output logic             BO,
  output logic             Z,
  output logic             V
);

  localparam int Half     = Width / 2;
  localparam int HalfLvls = $clog2(Half);

  if (!(Width == 8 || Width == 16 || Width == 32 || Width == 64)) begin : g_bad_width
    $error("prefix_sub_pipe: Width must be 8, 16, 32 or 64");
  end

  // Handshake / control
  logic             rdy_en_q, rdy_en_d;
  logic             vld_p1_q, vld_p1_d;
  logic             vld_p2_q, vld_p2_d;
  logic             s2_adv;
  logic             in_fire;

  // Stage-1 data
  logic [Width-1:0] p_p1_q, p_p1_d;
  logic [Width-1:0] gpre_p1_q, gpre_p1_d;
  logic [Width-1:0] ppre_p1_q, ppre_p1_d;
  logic             c0_p1_q, c0_p1_d;
  logic             a_msb_p1_q, a_msb_p1_d;
  logic             b_msb_p1_q, b_msb_p1_d;

  // Stage-2 (output) data
  logic [Width-1:0] d_p2_q, d_p2_d;
  logic             bo_p2_q, bo_p2_d;
  logic             z_p2_q, z_p2_d;
  logic             v_p2_q, v_p2_d;

  // Stage-2 combinational helpers
  logic [Width:0]   carry;
  logic             lo_cout;
  logic [Width-1:0] d_new;

  // Per-half prefix tree levels; level 0 is the raw bitwise P/G.
  logic [HalfLvls:0][Width-1:0] g_lvl;
  logic [HalfLvls:0][Width-1:0] p_lvl;

  // ---- Stage 0 -> Stage 1 boundary: bitwise P/G and half-local prefix ----
  assign g_lvl[0] = A & ~B;
  assign p_lvl[0] = A ^ ~B;

  for (genvar l = 0; l < HalfLvls; l++) begin : g_level
    for (genvar i = 0; i < Width; i++) begin : g_bit
      // Span stays inside the bit's own half; the cross-half merge is stage 2.
      if ((i % Half) >= (1 << l)) begin : g_merge
        assign g_lvl[l+1][i] = g_lvl[l][i] | (p_lvl[l][i] & g_lvl[l][i-(1<<l)]);
        assign p_lvl[l+1][i] = p_lvl[l][i] & p_lvl[l][i-(1<<l)];
      end else begin : g_pass
        assign g_lvl[l+1][i] = g_lvl[l][i];
        assign p_lvl[l+1][i] = p_lvl[l][i];
      end
    end
  end

  // Handshake: in_ready never looks at in_valid; out_ready may pass through.
  always_comb begin
    s2_adv   = !vld_p2_q | out_ready;
    in_ready = rdy_en_q & (!vld_p1_q | s2_adv);
    in_fire  = in_valid & in_ready;
    rdy_en_d = 1'b1;
    vld_p1_d = in_fire | (vld_p1_q & !s2_adv);
    vld_p2_d = s2_adv ? vld_p1_q : vld_p2_q;
  end

  // Stage-1 next state: load a new operand pair on accept, otherwise hold.
  always_comb begin
    p_p1_d     = p_p1_q;
    gpre_p1_d  = gpre_p1_q;
    ppre_p1_d  = ppre_p1_q;
    c0_p1_d    = c0_p1_q;
    a_msb_p1_d = a_msb_p1_q;
    b_msb_p1_d = b_msb_p1_q;
    if (in_fire) begin
      p_p1_d     = p_lvl[0];
      gpre_p1_d  = g_lvl[HalfLvls];
      ppre_p1_d  = p_lvl[HalfLvls];
      c0_p1_d    = ~BI;
      a_msb_p1_d = A[Width-1];
      b_msb_p1_d = B[Width-1];
    end
  end

  // ---- Stage 1 -> Stage 2 boundary: final carry level, result and flags ----
  always_comb begin
    lo_cout  = gpre_p1_q[Half-1] | (ppre_p1_q[Half-1] & c0_p1_q);
    carry    = '0;
    carry[0] = c0_p1_q;
    for (int i = 0; i < Width; i++) begin
      if (i < Half) begin
        carry[i+1] = gpre_p1_q[i] | (ppre_p1_q[i] & c0_p1_q);
      end else begin
        carry[i+1] = gpre_p1_q[i] | (ppre_p1_q[i] & lo_cout);
      end
    end
    d_new = p_p1_q ^ carry[Width-1:0];

    d_p2_d  = d_p2_q;
    bo_p2_d = bo_p2_q;
    z_p2_d  = z_p2_q;
    v_p2_d  = v_p2_q;
    if (s2_adv && vld_p1_q) begin
      d_p2_d  = d_new;
      bo_p2_d = ~carry[Width];
      z_p2_d  = (d_new == '0);
      v_p2_d  = (a_msb_p1_q != b_msb_p1_q) && (d_new[Width-1] != a_msb_p1_q);
    end
  end

  // Control and visible outputs: cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      d_p2_q   <= '0;
      bo_p2_q  <= 1'b0;
      z_p2_q   <= 1'b0;
      v_p2_q   <= 1'b0;
    end else begin
      rdy_en_q <= rdy_en_d;
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      d_p2_q   <= d_p2_d;
      bo_p2_q  <= bo_p2_d;
      z_p2_q   <= z_p2_d;
      v_p2_q   <= v_p2_d;
    end
  end

  // Stage-1 data: qualified by vld_p1_q, so no reset is needed.
  always_ff @(posedge clk) begin
    p_p1_q     <= p_p1_d;
    gpre_p1_q  <= gpre_p1_d;
    ppre_p1_q  <= ppre_p1_d;
    c0_p1_q    <= c0_p1_d;
    a_msb_p1_q <= a_msb_p1_d;
    b_msb_p1_q <= b_msb_p1_d;
  end

  assign out_valid = vld_p2_q;
  assign D         = d_p2_q;
  assign BO        = bo_p2_q;
  assign Z         = z_p2_q;
  assign V         = v_p2_q;

endmodule

// File: tb/tb_prefix_sub_pipe.sv
// Testbench for prefix_sub_pipe: directed scenarios on an 8-bit instance and
// a randomized handshake sweep on 16- and 64-bit instances, checked against
// a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_prefix_sub_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic       iv8, ir8, or8, bi8, ov8, bo8, z8, v8;
  logic [7:0] a8, b8, d8;
  logic        iv16, ir16, or16, bi16, ov16, bo16, z16, v16;
  logic [15:0] a16, b16, d16;
  logic        iv64, ir64, or64, bi64, ov64, bo64, z64, v64;
  logic [63:0] a64, b64, d64;

  prefix_sub_pipe #(.Width(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8), .BI(bi8),
    .out_valid(ov8), .out_ready(or8), .D(d8), .BO(bo8), .Z(z8), .V(v8));
  prefix_sub_pipe #(.Width(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .A(a16), .B(b16), .BI(bi16),
    .out_valid(ov16), .out_ready(or16), .D(d16), .BO(bo16), .Z(z16), .V(v16));
  prefix_sub_pipe #(.Width(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64), .A(a64), .B(b64), .BI(bi64),
    .out_valid(ov64), .out_ready(or64), .D(d64), .BO(bo64), .Z(z64), .V(v64));

  // Reference: exact integer subtraction, returns {BO, Z, V, D(zero-extended)}.
  function automatic logic [66:0] ref_sub(input int w, input logic [63:0] a,
                                          input logic [63:0] b, input logic bi);
    logic [63:0]        mask, d;
    logic [64:0]        ua, ub, diff;
    logic signed [67:0] sa, sb, sr, lim, sbi;
    logic               bo, z, v;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    ua   = {1'b0, a & mask};
    ub   = {1'b0, b & mask};
    bo   = (ua < (ub + {64'd0, bi}));
    diff = ua - ub - {64'd0, bi};
    d    = diff[63:0] & mask;
    z    = (d == 64'd0);
    lim  = 68'sd1 <<< (w - 1);
    sa   = $signed({3'b000, ua});
    sb   = $signed({3'b000, ub});
    sbi  = $signed({67'd0, bi});
    if (ua[w-1]) sa = sa - (lim <<< 1);
    if (ub[w-1]) sb = sb - (lim <<< 1);
    sr   = sa - sb - sbi;
    v    = (sr >= lim) || (sr < -lim);
    return {bo, z, v, d};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    iv8 = 0; or8 = 1; a8 = '0; b8 = '0; bi8 = 0;
    iv16 = 0; or16 = 1; a16 = '0; b16 = '0; bi16 = 0;
    iv64 = 0; or64 = 1; a64 = '0; b64 = '0; bi64 = 0;
    #2;
    n_checks++;
    if ({ov8, d8, bo8, z8, v8} !== 12'h000) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 000", {ov8, d8, bo8, z8, v8});
    end
    n_checks++;
    if (ir8 !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", ir8); end
    @(negedge clk); #2;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (ir8 !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge: got %b want 0", ir8); end
    @(negedge clk);
    n_checks++;
    if ({ir8, ov8} !== 2'b10) begin
      n_fail++; $display("FAIL ready_after_edge: got ir/ov %b want 10", {ir8, ov8});
    end
  endtask

  task automatic test_basic();
    @(negedge clk);
    a8 = 8'h05; b8 = 8'h03; bi8 = 0; iv8 = 1; or8 = 1;
    #1;
    n_checks++;
    if (ir8 !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b want 1", ir8); end
    @(negedge clk);
    iv8 = 0; a8 = 8'($urandom); b8 = 8'($urandom);
    n_checks++;
    if (ov8 !== 1'b0) begin n_fail++; $display("FAIL basic_early: out_valid %b want 0", ov8); end
    @(negedge clk);
    n_checks++;
    if ({ov8, d8, bo8, z8, v8} !== {1'b1, 8'h02, 3'b000}) begin
      n_fail++; $display("FAIL basic_result: got %h want %h", {ov8, d8, bo8, z8, v8}, {1'b1, 8'h02, 3'b000});
    end
    @(negedge clk);
    n_checks++;
    if (ov8 !== 1'b0) begin n_fail++; $display("FAIL basic_one_cycle: out_valid %b want 0", ov8); end
  endtask

  // Borrow, wrap and A==B boundaries, issued back to back.
  task automatic test_borrow();
    logic [7:0]  ta[4] = '{8'h00, 8'h00, 8'h3C, 8'h3C};
    logic [7:0]  tb[4] = '{8'h01, 8'hFF, 8'h3C, 8'h3C};
    logic        tc[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [10:0] te[4] = '{{8'hFF, 3'b100}, {8'h00, 3'b110}, {8'h00, 3'b010}, {8'hFF, 3'b100}};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        n_checks++;
        if ({ov8, d8, bo8, z8, v8} !== {1'b1, te[k-2]}) begin
          n_fail++; $display("FAIL borrow_%0d: got %h want %h", k - 2, {ov8, d8, bo8, z8, v8}, {1'b1, te[k-2]});
        end
      end
      if (k < 4) begin iv8 = 1; a8 = ta[k]; b8 = tb[k]; bi8 = tc[k]; end
      else iv8 = 0;
    end
    @(negedge clk);
    n_checks++;
    if (ov8 !== 1'b0) begin n_fail++; $display("FAIL borrow_drain: out_valid %b want 0", ov8); end
  endtask

  task automatic test_overflow();
    logic [7:0]  ta[2] = '{8'h80, 8'h10};
    logic [7:0]  tb[2] = '{8'h01, 8'h0F};
    logic        tc[2] = '{1'b0, 1'b1};
    logic [10:0] te[2] = '{{8'h7F, 3'b001}, {8'h00, 3'b010}};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        n_checks++;
        if ({ov8, d8, bo8, z8, v8} !== {1'b1, te[k-2]}) begin
          n_fail++; $display("FAIL overflow_%0d: got %h want %h", k - 2, {ov8, d8, bo8, z8, v8}, {1'b1, te[k-2]});
        end
      end
      if (k < 2) begin iv8 = 1; a8 = ta[k]; b8 = tb[k]; bi8 = tc[k]; end
      else iv8 = 0;
    end
  endtask

  task automatic test_backpressure();
    logic [7:0]  ta[4] = '{8'h05, 8'h09, 8'h20, 8'h03};
    logic [7:0]  tb[4] = '{8'h01, 8'h02, 8'h10, 8'h03};
    logic [10:0] te[4] = '{{8'h04, 3'b000}, {8'h07, 3'b000}, {8'h10, 3'b000}, {8'h00, 3'b010}};
    int idx = 0;
    int rcv = 0;
    for (int k = 0; k < 20 && rcv < 4; k++) begin
      @(negedge clk);
      or8 = (k >= 5);
      if (idx < 4) begin iv8 = 1; a8 = ta[idx]; b8 = tb[idx]; bi8 = 0; end
      else iv8 = 0;
      #1;
      if (k >= 2 && k <= 4) begin
        n_checks++;
        if ({ov8, d8, ir8} !== {1'b1, 8'h04, 1'b0}) begin
          n_fail++; $display("FAIL stall_hold_%0d: got ov/D/ir %h want %h", k, {ov8, d8, ir8}, {1'b1, 8'h04, 1'b0});
        end
      end
      if (k >= 5 && k <= 8) begin
        n_checks++;
        if (ov8 !== 1'b1) begin n_fail++; $display("FAIL stream_gap_%0d: out_valid %b want 1", k, ov8); end
      end
      if (ov8 && or8) begin
        n_checks++;
        if ({d8, bo8, z8, v8} !== te[rcv]) begin
          n_fail++; $display("FAIL bp_result_%0d: got %h want %h", rcv, {d8, bo8, z8, v8}, te[rcv]);
        end
        rcv++;
      end
      if (iv8 && ir8) idx++;
      if (k == 4) begin
        n_checks++;
        if (idx !== 2) begin n_fail++; $display("FAIL stall_accepts: got %0d want 2", idx); end
      end
    end
    n_checks++;
    if (rcv !== 4) begin n_fail++; $display("FAIL bp_drain: received %0d want 4", rcv); end
    iv8 = 0;
    @(negedge clk);
    n_checks++;
    if (ov8 !== 1'b0) begin n_fail++; $display("FAIL bp_empty: out_valid %b want 0", ov8); end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    or8 = 1; iv8 = 1; a8 = 8'h07; b8 = 8'h02; bi8 = 0;
    @(negedge clk);
    a8 = 8'h08; b8 = 8'h01;
    @(negedge clk);
    iv8 = 0; or8 = 0;
    #1;
    n_checks++;
    if ({ov8, d8} !== {1'b1, 8'h05}) begin
      n_fail++; $display("FAIL midflight_pre: got %h want %h", {ov8, d8}, {1'b1, 8'h05});
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ov8, d8, bo8, z8, v8, ir8} !== 13'h0) begin
      n_fail++; $display("FAIL midflight_clear: got %h want 0000", {ov8, d8, bo8, z8, v8, ir8});
    end
    #1 rst_n = 1'b1;
    or8 = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (ov8 !== 1'b0) begin n_fail++; $display("FAIL midflight_idle_%0d: out_valid %b want 0", k, ov8); end
    end
    @(negedge clk);
    iv8 = 1; a8 = 8'h33; b8 = 8'h11; bi8 = 0;
    #1;
    n_checks++;
    if (ir8 !== 1'b1) begin n_fail++; $display("FAIL midflight_ready: got %b want 1", ir8); end
    @(negedge clk);
    iv8 = 0;
    n_checks++;
    if (ov8 !== 1'b0) begin n_fail++; $display("FAIL midflight_early: out_valid %b want 0", ov8); end
    @(negedge clk);
    n_checks++;
    if ({ov8, d8, bo8, z8, v8} !== {1'b1, 8'h22, 3'b000}) begin
      n_fail++; $display("FAIL midflight_new: got %h want %h", {ov8, d8, bo8, z8, v8}, {1'b1, 8'h22, 3'b000});
    end
    @(negedge clk);
    n_checks++;
    if (ov8 !== 1'b0) begin n_fail++; $display("FAIL midflight_after: out_valid %b want 0", ov8); end
  endtask

  task automatic test_random();
    localparam int N = 10000;
    logic [66:0] q16[$];
    logic [66:0] q64[$];
    logic [66:0] exp;
    logic [67:0] snap16, snap64;
    logic        stall16 = 0, stall64 = 0;
    int sent16 = 0, recv16 = 0, sent64 = 0, recv64 = 0;
    int cyc = 0;
    while ((recv16 < N || recv64 < N) && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (stall16) begin
        n_checks++;
        if ({ov16, bo16, z16, v16, 48'd0, d16} !== snap16) begin
          n_fail++; $display("FAIL hold16: got %h want %h", {ov16, bo16, z16, v16, 48'd0, d16}, snap16);
        end
      end
      if (stall64) begin
        n_checks++;
        if ({ov64, bo64, z64, v64, d64} !== snap64) begin
          n_fail++; $display("FAIL hold64: got %h want %h", {ov64, bo64, z64, v64, d64}, snap64);
        end
      end
      or16 = ($urandom_range(0, 3) != 0);
      iv16 = (sent16 < N) && ($urandom_range(0, 3) != 0);
      a16 = 16'($urandom); b16 = 16'($urandom); bi16 = 1'($urandom_range(0, 1));
      or64 = ($urandom_range(0, 3) != 0);
      iv64 = (sent64 < N) && ($urandom_range(0, 3) != 0);
      a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; bi64 = 1'($urandom_range(0, 1));
      #1;
      if (iv16 && ir16) begin q16.push_back(ref_sub(16, {48'd0, a16}, {48'd0, b16}, bi16)); sent16++; end
      if (iv64 && ir64) begin q64.push_back(ref_sub(64, a64, b64, bi64)); sent64++; end
      if (ov16 && or16) begin
        n_checks++;
        if (q16.size() == 0) begin
          n_fail++; $display("FAIL rand16_extra: got %h want no output", d16);
        end else begin
          exp = q16.pop_front();
          if ({bo16, z16, v16, 48'd0, d16} !== exp) begin
            n_fail++; $display("FAIL rand16: got %h want %h", {bo16, z16, v16, 48'd0, d16}, exp);
          end
        end
        recv16++;
      end
      if (ov64 && or64) begin
        n_checks++;
        if (q64.size() == 0) begin
          n_fail++; $display("FAIL rand64_extra: got %h want no output", d64);
        end else begin
          exp = q64.pop_front();
          if ({bo64, z64, v64, d64} !== exp) begin
            n_fail++; $display("FAIL rand64: got %h want %h", {bo64, z64, v64, d64}, exp);
          end
        end
        recv64++;
      end
      stall16 = ov16 && !or16;
      snap16  = {ov16, bo16, z16, v16, 48'd0, d16};
      stall64 = ov64 && !or64;
      snap64  = {ov64, bo64, z64, v64, d64};
    end
    iv16 = 0; iv64 = 0;
    n_checks++;
    if (recv16 !== N || q16.size() != 0) begin
      n_fail++; $display("FAIL rand16_count: received %0d want %0d (pending %0d)", recv16, N, q16.size());
    end
    n_checks++;
    if (recv64 !== N || q64.size() != 0) begin
      n_fail++; $display("FAIL rand64_count: received %0d want %0d (pending %0d)", recv64, N, q64.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_overflow();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
